// File: rtl/fpu_mul_sig_seq_if.sv
// Operand/result handshake bundle for the iterative significand multiplier.
// The master side drives operands and flow control; the slave side is the multiplier.
interface fpu_mul_sig_seq_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  logic              start_i;
  logic              ready_o;
  logic              sign_a_i;
  logic              sign_b_i;
  logic [EXP_W-1:0]  exp_a_i;
  logic [EXP_W-1:0]  exp_b_i;
  logic [MANT_W-1:0] mant_a_i;
  logic [MANT_W-1:0] mant_b_i;
  logic              kill_i;
  logic              valid_o;
  logic              ready_i;
  logic              sign_o;
  logic [EXP_W+1:0]  exp_o;
  logic [MANT_W-1:0] mant_o;
  logic [2:0]        lrs_o;
  logic              busy_o;

  modport master (
    output start_i, sign_a_i, sign_b_i, exp_a_i, exp_b_i, mant_a_i, mant_b_i,
           kill_i, ready_i,
    input  ready_o, valid_o, sign_o, exp_o, mant_o, lrs_o, busy_o
  );

  modport slave (
    input  start_i, sign_a_i, sign_b_i, exp_a_i, exp_b_i, mant_a_i, mant_b_i,
           kill_i, ready_i,
    output ready_o, valid_o, sign_o, exp_o, mant_o, lrs_o, busy_o
  );
endinterface

// File: rtl/fpu_mul_sig_seq.sv
// Iterative shift-and-add significand multiplier with normalisation and {L,R,S} extraction.
// Optional FPU_MUL_EARLY_ZERO_EN: a zero significand skips MUL and goes straight to NORM.
//
// state | meaning
// IDLE  | waiting for operands
// MUL   | retiring BITS_PER_CYCLE multiplier bits per cycle
// NORM  | normalise product, load output registers
// DONE  | result valid, waiting for downstream ready_i
module fpu_mul_sig_seq #(
  parameter int MANT_W         = 24,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EXP_W          = 8,
  parameter int BIAS           = 127
) (
  input logic               clk_i,
  input logic               reset_i,
  fpu_mul_sig_seq_if.slave  bus
);
  localparam int N_CYC = MANT_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N_CYC + 1);
  localparam int P_W   = 2 * MANT_W;
  localparam logic [EXP_W+1:0] BIAS_E = (EXP_W+2)'(BIAS);
  localparam logic [EXP_W+1:0] ONE_E  = (EXP_W+2)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [P_W-1:0]    acc, acc_add, mcand;
  logic [MANT_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic [EXP_W+1:0]  exp_e;
  logic              sign_r;
  logic              accept, op_zero;

  logic [MANT_W-1:0] norm_mant, mant_q;
  logic [2:0]        norm_lrs, lrs_q;
  logic [EXP_W+1:0]  norm_exp, exp_q;
  logic              sign_q;

`ifdef FPU_MUL_EARLY_ZERO_EN
  assign op_zero = (bus.mant_a_i == '0) | (bus.mant_b_i == '0);
`else
  assign op_zero = 1'b0;
`endif

  assign bus.ready_o = (state == S_IDLE) | ((state == S_DONE) & bus.ready_i);
  assign accept      = bus.start_i & bus.ready_o & ~bus.kill_i;
  assign bus.valid_o = (state == S_DONE);
  assign bus.busy_o  = (state == S_MUL) | (state == S_NORM);
  assign bus.sign_o  = sign_q;
  assign bus.exp_o   = exp_q;
  assign bus.mant_o  = mant_q;
  assign bus.lrs_o   = lrs_q;

  always_comb begin
    acc_add = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) acc_add = acc_add + (mcand << i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = op_zero ? S_NORM : S_MUL;
      S_MUL:  if (cnt == CNT_W'(1)) state_nxt = S_NORM;
      S_NORM: state_nxt = S_DONE;
      S_DONE: begin
        if (accept)            state_nxt = op_zero ? S_NORM : S_MUL;
        else if (bus.ready_i)  state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.kill_i) state_nxt = S_IDLE;
  end

  // Product of two [1,2) significands lies in [1,4): at most one position of normalisation.
  always_comb begin
    if (acc[P_W-1]) begin
      norm_mant = acc[P_W-1:MANT_W];
      norm_lrs  = {acc[MANT_W], acc[MANT_W-1], |acc[MANT_W-2:0]};
      norm_exp  = exp_e + ONE_E;
    end else begin
      norm_mant = acc[P_W-2:MANT_W-1];
      norm_lrs  = {acc[MANT_W-1], acc[MANT_W-2], |acc[MANT_W-3:0]};
      norm_exp  = exp_e;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      exp_e  <= '0;
      sign_r <= 1'b0;
      mant_q <= '0;
      lrs_q  <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc    <= '0;
        mcand  <= {{MANT_W{1'b0}}, bus.mant_a_i};
        mplier <= bus.mant_b_i;
        cnt    <= CNT_W'(N_CYC);
        exp_e  <= {2'b00, bus.exp_a_i} + {2'b00, bus.exp_b_i} - BIAS_E;
        sign_r <= bus.sign_a_i ^ bus.sign_b_i;
      end else if (state == S_MUL) begin
        acc    <= acc_add;
        mcand  <= mcand << BITS_PER_CYCLE;
        mplier <= mplier >> BITS_PER_CYCLE;
        cnt    <= cnt - CNT_W'(1);
      end
      if ((state == S_NORM) && (state_nxt == S_DONE)) begin
        mant_q <= norm_mant;
        lrs_q  <= norm_lrs;
        exp_q  <= norm_exp;
        sign_q <= sign_r;
      end
    end
  end
endmodule

// File: doc/fpu_mul_sig_seq.md
Name: fpu_mul_sig_seq

Overview:
Iterative single-precision significand multiplier that sits directly upstream of the FPU multiply rounding stage. It accepts unpacked operands (sign, biased exponent, 24-bit significand with hidden bit). It computes the 48-bit product by shift-and-add over several cycles, then normalises it. It emits the truncated 24-bit significand, an unrounded signed exponent, the result sign and the {L,R,S} triple that the rounder consumes. Special-value classification (NaN/Inf/zero/subnormal) is handled by the surrounding FPU, not here.

Parameters:
MANT_W, 24, significand width including hidden bit; product is 2*MANT_W bits.
BITS_PER_CYCLE, 1, multiplier bits retired per cycle (1, 2 or 4); MANT_W must be divisible by it.
EXP_W, 8, biased input exponent width.
BIAS, 127, exponent bias.

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous reset, active-high
start_i  input  1  operand valid; accepted only when ready_o=1
ready_o  output  1  block can accept start_i this cycle
sign_a_i  input  1  sign of operand A
sign_b_i  input  1  sign of operand B
exp_a_i  input  EXP_W  biased exponent A
exp_b_i  input  EXP_W  biased exponent B
mant_a_i  input  MANT_W  significand A, hidden bit included
mant_b_i  input  MANT_W  significand B, hidden bit included
kill_i  input  1  flush; abandons any operation in progress
valid_o  output  1  result valid; held until ready_i
ready_i  input  1  downstream (rounder) accepts the result
sign_o  output  1  sign_a ^ sign_b
exp_o  output  EXP_W+2  signed two's-complement unrounded exponent
mant_o  output  MANT_W  normalised, truncated significand
lrs_o  output  3  {L,R,S}: [2]=LSB kept, [1]=round bit, [0]=sticky
busy_o  output  1  state is MUL or NORM

Behaviour:
- Reset (reset_i=1 at a clock edge):
  - state=IDLE.
  - valid_o=0, busy_o=0, ready_o=1.
  - sign_o=0, exp_o=0, mant_o=0, lrs_o=0.
  - Reset mid-operation discards all work; no valid_o is produced.
- States IDLE, MUL, NORM, DONE.
- ready_o = (state==IDLE) | (state==DONE & ready_i).
- IDLE:
  - On start_i: latch operands, clear the 2*MANT_W accumulator, load the cycle counter with MANT_W/BITS_PER_CYCLE, go to MUL.
  - start_i without ready_o is ignored; operands are not latched.
- MUL:
  - Each cycle, add (multiplicand × low BITS_PER_CYCLE multiplier bits) into the accumulator.
  - Shift the multiplier right by BITS_PER_CYCLE and the multiplicand left by BITS_PER_CYCLE; decrement the counter.
  - When the counter reaches 1, go to NORM.
  - The accumulator is exactly 2*MANT_W bits and never overflows.
- NORM (1 cycle), with product P[2*MANT_W-1:0] and e = exp_a + exp_b − BIAS, computed signed at EXP_W+2 bits:
  - If P[MSB]=1: mant_o=P[MSB:MANT_W], L=P[MANT_W], R=P[MANT_W−1], S=|P[MANT_W−2:0], exp_o=e+1.
  - Else: mant_o=P[MSB−1:MANT_W−1], L=P[MANT_W−1], R=P[MANT_W−2], S=|P[MANT_W−3:0], exp_o=e.
  - Then go to DONE.
- DONE:
  - valid_o=1; outputs stable while valid_o=1 & ready_i=0.
  - ready_i=1 & start_i=1: accept new operands same cycle, go to MUL (back-to-back, no bubble).
  - ready_i=1 & start_i=0: go to IDLE.
- Latency: start acceptance to valid_o = MANT_W/BITS_PER_CYCLE + 1 cycles (25 with defaults).
- kill_i=1 in any state: next state IDLE, valid_o=0 next cycle, outputs hold last values.
  - kill_i outranks start_i and ready_i in the same cycle; no acceptance occurs.
- Zero significand inputs: product 0, mant_o=0, lrs_o=000, exp_o=e. There is no special handling.
- Output registers update only on the NORM→DONE transition.

Optional Feature:
FPU_MUL_EARLY_ZERO_EN
- Defined:
  - Detection: at acceptance, if mant_a_i==0 or mant_b_i==0, skip MUL and go directly to NORM with accumulator 0.
  - Latency: valid_o 1 cycle after acceptance.
  - Outputs: mant_o=0, lrs_o=000, exp_o=e, sign_o = sign_a^sign_b.
- Undefined: zero operands take the full iterative latency. Results are identical either way; only timing differs.

Test Plan:
- 1.0×1.0: exp 127/127, mant 0x800000/0x800000, signs 0/0 -> after 25 cycles valid_o=1, mant_o=0x800000, exp_o=127, lrs_o=000, sign_o=0.
- 1.5×−1.5: mant 0xC00000/0xC00000, sign_b=1 -> mant_o=0x900000, exp_o=128, lrs_o=000, sign_o=1.
- Sticky only: mant 0xFFFFFF/0xFFFFFF, exp 127/127 -> P=0xFFFFFE000001, mant_o=0xFFFFFE, exp_o=128, lrs_o=001.
- L and R set: mant 0x800001/0xC00000 -> mant_o=0xC00001, lrs_o=110, exp_o=127. Hold ready_i=0 for 5 cycles: outputs stable, ready_o=0. Then ready_i=1 with start_i=1: next operation accepted with no idle cycle.
- Kill: assert kill_i at cycle 10 of MUL -> IDLE next cycle, no valid_o. A subsequent 1.0×1.0 produces the correct result. Repeat with reset_i mid-MUL: same outcome, outputs zero.
- Zero/underflow exponent: mant_a=0, exp 1/1 -> mant_o=0, lrs_o=000, exp_o=−125 (0x383 at 10 bits). With FPU_MUL_EARLY_ZERO_EN, valid_o 1 cycle after acceptance; without it, 25 cycles.
